// File: rtl/syn_ram_ctrl.sv
// syn_ram_ctrl
// Burst sequencer in front of a 16x2 synchronous RAM. Accepts read/write
// burst requests on a valid/ready handshake, streams write beats in with
// per-beat flow control, drives every RAM control pin, and returns read
// data as a valid-qualified stream with a last-beat marker.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        burst request handshake
//   req_write, req_addr,
//   req_len                    burst direction, start address, length-1
//   wr_valid/wr_ready, wr_data write beat stream
//   rd_valid, rd_data, rd_last read beat stream (no backpressure)
//   done                       one-cycle pulse when a burst completes
//   ram_we, ram_oe, ram_rst,
//   ram_addr, ram_din          RAM control and write data
//   ram_dout                   RAM registered read data
module syn_ram_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_data,
  output logic       rd_valid,
  output logic [1:0] rd_data,
  output logic       rd_last,
  output logic       done,
  output logic       ram_we,
  output logic       ram_oe,
  output logic       ram_rst,
  output logic [3:0] ram_addr,
  output logic [1:0] ram_din,
  input  logic [1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] beat_q, beat_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       done_q, done_d;

  // Next-state logic. Address and beat counters wrap modulo 16, so a
  // 16-beat burst touches every word exactly once from any start address.
  // The read-valid flag is set one cycle after each issue to match the
  // RAM's registered read latency; the last flag marks the beat_cnt = 0 issue.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          beat_d  = req_len;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          addr_d = addr_q + 4'd1;
          beat_d = beat_q - 4'd1;
          if (beat_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        addr_d     = addr_q + 4'd1;
        beat_d     = beat_q - 4'd1;
        rd_valid_d = 1'b1;
        if (beat_q == 4'd0) begin
          state_d   = DRAIN;
          rd_last_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight and clears the
  // read-return pipeline so no stray rd_valid or done can follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 4'd0;
      beat_q     <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

  // Idle holds the RAM output register cleared so rd_data never sees stale
  // words between bursts.
  assign req_ready = (state_q == IDLE);
  assign ram_rst   = (state_q == IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign ram_we    = (state_q == WRITE) && wr_valid;
  assign ram_din   = (state_q == WRITE) ? wr_data : 2'd0;
  assign ram_oe    = (state_q == READ) || (state_q == DRAIN);
  assign ram_addr  = addr_q;

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? ram_dout : 2'd0;
  assign rd_last   = rd_valid_q & rd_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_syn_ram_ctrl.sv
// tb_syn_ram_ctrl
// Directed bench for syn_ram_ctrl with a behavioural 16x2 synchronous RAM
// (registered read, synchronous output clear) attached to the RAM pins.
module tb_syn_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_addr;
  logic [3:0] req_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_data;
  logic       rd_valid;
  logic [1:0] rd_data;
  logic       rd_last;
  logic       done;
  logic       ram_we;
  logic       ram_oe;
  logic       ram_rst;
  logic [3:0] ram_addr;
  logic [1:0] ram_din;
  logic [1:0] ram_dout;

  logic [1:0] mem [16];
  logic [1:0] expFull [16];
  logic [1:0] expPost [8];
  logic [3:0] wAddr [4];
  logic [1:0] wData [4];

  int assertCount;
  int failCount;

  syn_ram_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_rst  (ram_rst),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write on we, output register cleared by rst,
  // otherwise loaded from the addressed word when oe is high
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_rst) ram_dout <= 2'd0;
    else if (ram_oe) ram_dout <= mem[ram_addr];
  end

  task automatic applyStimulus(input logic rv, input logic rw, input logic [3:0] ra,
                               input logic [3:0] rl, input logic wv, input logic [1:0] wd);
    req_valid = rv;
    req_write = rw;
    req_addr  = ra;
    req_len   = rl;
    wr_valid  = wv;
    wr_data   = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: drive at the falling edge, check 1 unit later
  initial begin
    assertCount = 0;
    failCount   = 0;
    ram_dout    = 2'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'(i);
    wAddr   = '{4'd14, 4'd15, 4'd0, 4'd1};
    wData   = '{2'd1, 2'd2, 2'd3, 2'd0};
    expFull = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1,
                2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    expPost = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd3};

    // Reset held for 3 cycles
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", 4'(req_ready), 4'd1);
    checkOutput("rst_wr_ready",  4'(wr_ready),  4'd0);
    checkOutput("rst_rd_valid",  4'(rd_valid),  4'd0);
    checkOutput("rst_rd_data",   4'(rd_data),   4'd0);
    checkOutput("rst_rd_last",   4'(rd_last),   4'd0);
    checkOutput("rst_done",      4'(done),      4'd0);
    checkOutput("rst_ram_we",    4'(ram_we),    4'd0);
    checkOutput("rst_ram_oe",    4'(ram_oe),    4'd0);
    checkOutput("rst_ram_rst",   4'(ram_rst),   4'd1);
    checkOutput("rst_ram_addr",  ram_addr,      4'd0);
    checkOutput("rst_ram_din",   4'(ram_din),   4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("post_rst_done",      4'(done),      4'd0);
      checkOutput("post_rst_req_ready", 4'(req_ready), 4'd1);
    end

    // Write burst 14,15,0,1 with wr_valid high (also high while idle)
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'd14, 4'd3, 1'b1, 2'd1);
    #1;
    checkOutput("wr_idle_req_ready", 4'(req_ready), 4'd1);
    checkOutput("wr_idle_we",        4'(ram_we),    4'd0);
    checkOutput("wr_idle_wr_ready",  4'(wr_ready),  4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, wData[i]);
      #1;
      checkOutput("wr_beat_we",       4'(ram_we),   4'd1);
      checkOutput("wr_beat_wr_ready", 4'(wr_ready), 4'd1);
      checkOutput("wr_beat_addr",     ram_addr,     wAddr[i]);
      checkOutput("wr_beat_din",      4'(ram_din),  4'(wData[i]));
      checkOutput("wr_beat_ram_rst",  4'(ram_rst),  4'd0);
      checkOutput("wr_beat_done",     4'(done),     4'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd2);
    #1;
    checkOutput("wr_done",           4'(done),      4'd1);
    checkOutput("wr_done_we",        4'(ram_we),    4'd0);
    checkOutput("wr_done_wr_ready",  4'(wr_ready),  4'd0);
    checkOutput("wr_done_req_ready", 4'(req_ready), 4'd1);

    // Full 16-beat read from 14 (wr_valid high must be ignored)
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'd14, 4'd15, 1'b1, 2'd0);
    #1;
    checkOutput("rd_acc_done", 4'(done), 4'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd0);
    #1;
    checkOutput("rd_issue_oe",       4'(ram_oe),   4'd1);
    checkOutput("rd_issue_addr",     ram_addr,     4'd14);
    checkOutput("rd_issue_we",       4'(ram_we),   4'd0);
    checkOutput("rd_issue_wr_ready", 4'(wr_ready), 4'd0);
    checkOutput("rd_issue_rd_valid", 4'(rd_valid), 4'd0);
    checkOutput("rd_issue_ram_rst",  4'(ram_rst),  4'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      checkOutput("rd_full_valid", 4'(rd_valid), 4'd1);
      checkOutput("rd_full_data",  4'(rd_data),  4'(expFull[k]));
      checkOutput("rd_full_last",  4'(rd_last),  4'(k == 15));
      checkOutput("rd_full_done",  4'(done),     4'd0);
    end
    checkOutput("rd_drain_oe", 4'(ram_oe), 4'd1);
    @(negedge clk);
    #1;
    checkOutput("rd_full_done_pulse", 4'(done),     4'd1);
    checkOutput("rd_full_end_valid",  4'(rd_valid), 4'd0);
    checkOutput("rd_full_end_data",   4'(rd_data),  4'd0);
    checkOutput("rd_full_end_oe",     4'(ram_oe),   4'd0);

    // Two-beat write to 5 with a 2-cycle wr_valid gap
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'd5, 4'd1, 1'b0, 2'd0);
    #1;
    checkOutput("stall_acc_req_ready", 4'(req_ready), 4'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd2);
    #1;
    checkOutput("stall_b0_we",   4'(ram_we),  4'd1);
    checkOutput("stall_b0_addr", ram_addr,    4'd5);
    checkOutput("stall_b0_din",  4'(ram_din), 4'd2);
    repeat (2) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
      #1;
      checkOutput("stall_gap_we",       4'(ram_we),   4'd0);
      checkOutput("stall_gap_wr_ready", 4'(wr_ready), 4'd1);
      checkOutput("stall_gap_addr",     ram_addr,     4'd6);
      checkOutput("stall_gap_done",     4'(done),     4'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd3);
    #1;
    checkOutput("stall_b1_we",   4'(ram_we),  4'd1);
    checkOutput("stall_b1_addr", ram_addr,    4'd6);
    checkOutput("stall_b1_din",  4'(ram_din), 4'd3);
    checkOutput("stall_b1_done", 4'(done),    4'd0);

    // Back-to-back single-beat read of 6 offered during the done cycle
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'd6, 4'd0, 1'b0, 2'd0);
    #1;
    checkOutput("b2b_done",      4'(done),      4'd1);
    checkOutput("b2b_req_ready", 4'(req_ready), 4'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    #1;
    checkOutput("b2b_issue_oe",    4'(ram_oe),   4'd1);
    checkOutput("b2b_issue_addr",  ram_addr,     4'd6);
    checkOutput("b2b_issue_valid", 4'(rd_valid), 4'd0);
    checkOutput("b2b_issue_done",  4'(done),     4'd0);
    @(negedge clk);
    #1;
    checkOutput("b2b_rd_valid", 4'(rd_valid), 4'd1);
    checkOutput("b2b_rd_data",  4'(rd_data),  4'd3);
    checkOutput("b2b_rd_last",  4'(rd_last),  4'd1);
    @(negedge clk);
    #1;
    checkOutput("b2b_rd_done",  4'(done),     4'd1);
    checkOutput("b2b_end_valid", 4'(rd_valid), 4'd0);

    // 6-beat read from 0, reset asserted during the third issue
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd5, 1'b0, 2'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    checkOutput("mid_beat0_valid", 4'(rd_valid), 4'd1);
    checkOutput("mid_beat0_data",  4'(rd_data),  4'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid",     4'(rd_valid),  4'd0);
    checkOutput("mid_rst_last",      4'(rd_last),   4'd0);
    checkOutput("mid_rst_oe",        4'(ram_oe),    4'd0);
    checkOutput("mid_rst_req_ready", 4'(req_ready), 4'd1);
    checkOutput("mid_rst_ram_rst",   4'(ram_rst),   4'd1);
    checkOutput("mid_rst_addr",      ram_addr,      4'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("mid_hold_valid", 4'(rd_valid), 4'd0);
      checkOutput("mid_hold_done",  4'(done),     4'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("mid_after_valid", 4'(rd_valid), 4'd0);
      checkOutput("mid_after_done",  4'(done),     4'd0);
    end

    // Read back words 0..7 to confirm memory unchanged by the reset
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd7, 1'b0, 2'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    #1;
    checkOutput("post_issue_oe",   4'(ram_oe), 4'd1);
    checkOutput("post_issue_addr", ram_addr,   4'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      checkOutput("post_valid", 4'(rd_valid), 4'd1);
      checkOutput("post_data",  4'(rd_data),  4'(expPost[k]));
      checkOutput("post_last",  4'(rd_last),  4'(k == 7));
    end
    @(negedge clk);
    #1;
    checkOutput("post_done", 4'(done), 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
